fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that owns the architectural PC register. It issues single-outstanding fetch requests to instruction memory over a valid/ready handshake and buffers each returned word for decode. It accepts redirects, meaning the resolved target from the next-PC logic for JAL, JALR and taken branches. Fetches stale at redirect time are squashed, so no wrong-path instruction reaches decode. It sits between the next-PC glue and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
All data/address widths use `DATA_WIDTH (32) from defines.vh.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  suppresses new fetch requests
redirect_valid  in  1  one-cycle pulse, redirect_pc is the new fetch target
redirect_pc  in  32  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  fetch address (= pc)
imem_rsp_valid  in  1  fetch data valid; exactly one per accepted request, 1+ cycles later
imem_rsp_data  in  32  fetched instruction word
if_valid  out  1  buffered instruction available to decode
if_ready  in  1  decode accepts instruction
if_instr  out  32  buffered instruction
if_pc  out  32  PC of buffered instruction
misalign_fault  out  1  sticky: redirect target not word-aligned

Behaviour:
- States: IDLE, REQ, WAIT_RSP, HOLD, DRAIN, HALT. All state, pc, instruction buffer and fault flag are registered.
- Reset (rst_n low, async):
  - state=IDLE, pc=RESET_PC, if_instr=0, if_pc=0, misalign_fault=0.
  - All outputs are 0 during reset.
  - IDLE -> REQ unconditionally on the first clock after reset release.
  - A reset mid-operation abandons any outstanding fetch. The memory shares rst_n, so no stale response arrives after reset.
- Combinational outputs:
  - imem_req_valid = (state==REQ) && !stall && !redirect_valid
  - imem_req_addr = pc
  - if_valid = (state==HOLD) && !redirect_valid
- Valid/ready rule: once imem_req_valid is high, pc does not change until the handshake completes. The only exception is a redirect, which forces valid low in that same cycle.
- Redirect handling:
  - Redirect has priority over every other event in every state except IDLE and HALT.
  - If redirect_pc[1:0] != 0: misalign_fault<=1, state<=HALT, pc unchanged.
  - Otherwise pc<=redirect_pc, with the next state given per state below.
- REQ:
  - On handshake (valid && ready): -> WAIT_RSP.
  - With stall: stay in REQ, no request issued.
  - Redirect: stay in REQ with the new pc; the request is issued next cycle.
- WAIT_RSP:
  - rsp_valid without redirect: if_instr<=rsp_data, if_pc<=pc, pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), -> HOLD.
  - rsp_valid with redirect in the same cycle: response discarded, -> REQ.
  - Redirect without rsp_valid: -> DRAIN.
- DRAIN (one stale response outstanding):
  - rsp_valid: data discarded, -> REQ.
  - Another redirect while draining: pc updated, remain in DRAIN. If rsp_valid is in the same cycle, -> REQ.
- HOLD:
  - if_ready: -> REQ.
  - Redirect: buffered instruction dropped (if_valid is low that cycle, so decode cannot take it), -> REQ.
  - stall has no effect on a HOLD already in progress.
- HALT: terminal until reset. No requests issued, if_valid=0, misalign_fault=1.
- Latency and throughput:
  - First request is on cycle 1 after reset release.
  - With zero-wait memory (rsp the cycle after the handshake), one instruction is delivered every 3 cycles.
- At most one request is outstanding at any time. No request is issued in WAIT_RSP or DRAIN.

Decomposition:
- Shared package / defines.vh:
  - `DATA_WIDTH
  - state encodings FETCH_IDLE, FETCH_REQ, FETCH_WAIT, FETCH_HOLD, FETCH_DRAIN, FETCH_HALT (3 bits)
  - `RESET_PC default
- The block is a single module; no sub-module is needed. The if_instr/if_pc buffer is a plain register pair inside fetch_ctrl.

Test Plan:
- Reset release, ready=1, rsp one cycle after accept, if_ready=1:
  - request addresses are 0x0, 0x4, 0x8
  - if_pc matches each; if_instr equals returned words
  - if_valid high one cycle per instruction, every 3 cycles
- imem_req_ready low for 5 cycles:
  - imem_req_valid stays high and addr stays 0x4 throughout
  - exactly one handshake occurs
- Redirect to 0x100 during WAIT_RSP for fetch at 0x8, rsp 3 cycles later:
  - response discarded, if_valid never asserted for 0x8
  - next request addr is 0x100
- Redirect to 0x200 in the same cycle as rsp_valid:
  - instruction discarded
  - next request addr is 0x200, if_pc of the next delivered instruction is 0x200
- Redirect to 0x202:
  - misalign_fault goes high and stays high
  - no further imem_req_valid
  - assert rst_n low: fault clears, fetch restarts at RESET_PC
- pc=0xFFFF_FFFC fetched, then if_ready held low 4 cycles with stall high:
  - if_valid held and if_pc stable at 0xFFFF_FFFC
  - next request addr is 0x0 only after stall drops

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared widths, reset-PC default, fetch FSM state encoding
// and a small alignment helper used by the fetch sequencer.
package fetch_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    FETCH_IDLE  = 3'd0,
    FETCH_REQ   = 3'd1,
    FETCH_WAIT  = 3'd2,
    FETCH_HOLD  = 3'd3,
    FETCH_DRAIN = 3'd4,
    FETCH_HALT  = 3'd5
  } fetch_state_e;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [DATA_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer owning the architectural PC.
// Issues one outstanding fetch at a time over a valid/ready request channel,
// buffers the returned word for decode, and squashes wrong-path fetches when
// a redirect arrives. A misaligned redirect target halts fetch until reset.
//
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   stall                              suppresses new fetch requests
//   redirect_valid, redirect_pc        one-cycle redirect to a new target
//   imem_req_valid/ready, imem_req_addr   fetch request channel (addr = pc)
//   imem_rsp_valid, imem_rsp_data      one response per accepted request
//   if_valid/ready, if_instr, if_pc    buffered instruction towards decode
//   misalign_fault                     sticky misaligned-redirect flag
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic                  misalign_fault
);

  fetch_state_e          state_r;
  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] if_instr_r;
  logic [DATA_WIDTH-1:0] if_pc_r;
  logic                  fault_r;
  logic                  redirect_ok_s;
  logic                  req_fire_s;

  // A redirect forces the request low in the same cycle so the PC is free
  // to change without breaking the valid/ready hold rule.
  assign imem_req_valid = (state_r == FETCH_REQ) && !stall && !redirect_valid;
  assign imem_req_addr  = pc_r;
  // Hide the buffered word during a redirect so decode cannot consume it.
  assign if_valid       = (state_r == FETCH_HOLD) && !redirect_valid;
  assign if_instr       = if_instr_r;
  assign if_pc          = if_pc_r;
  assign misalign_fault = fault_r;

  assign redirect_ok_s  = is_word_aligned(redirect_pc);
  assign req_fire_s     = imem_req_valid && imem_req_ready;

  // Fetch FSM: state, pc, instruction buffer and fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= FETCH_IDLE;
      pc_r       <= RESET_PC;
      if_instr_r <= 32'h0000_0000;
      if_pc_r    <= 32'h0000_0000;
      fault_r    <= 1'b0;
    end else begin
      case (state_r)
        FETCH_IDLE: state_r <= FETCH_REQ;
        FETCH_HALT: state_r <= FETCH_HALT;
        FETCH_REQ, FETCH_WAIT, FETCH_DRAIN, FETCH_HOLD: begin
          if (redirect_valid) begin
            if (!redirect_ok_s) begin
              fault_r <= 1'b1;
              state_r <= FETCH_HALT;
            end else begin
              pc_r <= redirect_pc;
              // With a fetch in flight, wait out its stale response unless
              // it is arriving right now.
              if ((state_r == FETCH_WAIT) || (state_r == FETCH_DRAIN)) begin
                state_r <= imem_rsp_valid ? FETCH_REQ : FETCH_DRAIN;
              end else begin
                state_r <= FETCH_REQ;
              end
            end
          end else begin
            case (state_r)
              FETCH_REQ: begin
                if (req_fire_s) begin
                  state_r <= FETCH_WAIT;
                end
              end
              FETCH_WAIT: begin
                if (imem_rsp_valid) begin
                  if_instr_r <= imem_rsp_data;
                  if_pc_r    <= pc_r;
                  pc_r       <= pc_r + 32'd4;
                  state_r    <= FETCH_HOLD;
                end
              end
              FETCH_DRAIN: begin
                if (imem_rsp_valid) begin
                  state_r <= FETCH_REQ;
                end
              end
              FETCH_HOLD: begin
                if (if_ready) begin
                  state_r <= FETCH_REQ;
                end
              end
              default: state_r <= FETCH_IDLE;
            endcase
          end
        end
        default: state_r <= FETCH_IDLE;
      endcase
    end
  end

endmodule
